// File: rtl/mmio_port_unit.sv
// MMIO peripheral for the MIPS MEM stage: output port, synchronized input port with
// sticky rising-edge flags, and a countdown timer with a sticky expiry flag.
module mmio_port_unit #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic        Hit,
    output logic [31:0] ReadData,
    output logic [31:0] PortOut,
    output logic        TimerIRQ
);

    localparam logic [2:0] OFF_PORT_OUT = 3'd0;
    localparam logic [2:0] OFF_PORT_IN  = 3'd1;
    localparam logic [2:0] OFF_EDGE     = 3'd2;
    localparam logic [2:0] OFF_TIMER    = 3'd3;
    localparam logic [2:0] OFF_STATUS   = 3'd4;

    logic [31:0] r_port_out;
    logic [31:0] r_count;
    logic [7:0]  r_sync1;
    logic [7:0]  r_sync2;
    logic [7:0]  r_sync3;
    logic [7:0]  r_flags;
    logic        r_expired;

    logic        w_hit;
    logic [2:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_port_out_wr;
    logic        w_timer_wr;
    logic        w_edge_clr;
    logic        w_status_clr;
    logic        w_expire_set;
    logic [7:0]  w_new_edges;
    logic        w_unused_addr;

    assign w_hit         = (Address[31:5] == BASE_ADDR[31:5]);
    assign w_off         = Address[4:2];
    assign w_unused_addr = &{1'b0, Address[1:0]};
    assign w_wr          = w_hit & MemWrite;
    assign w_rd          = w_hit & MemRead;

    assign w_port_out_wr = w_wr && (w_off == OFF_PORT_OUT);
    assign w_timer_wr    = w_wr && (w_off == OFF_TIMER);
    assign w_edge_clr    = w_rd && (w_off == OFF_EDGE);
    assign w_status_clr  = w_rd && (w_off == OFF_STATUS);

    // A TIMER write in the terminal cycle reloads instead of expiring.
    assign w_expire_set  = !w_timer_wr && (r_count == 32'd1);
    assign w_new_edges   = r_sync2 & ~r_sync3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_port_out <= 32'd0;
        end else if (w_port_out_wr) begin
            r_port_out <= WriteData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 8'd0;
            r_sync2 <= 8'd0;
            r_sync3 <= 8'd0;
        end else begin
            r_sync1 <= PortIn;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Set wins over read-to-clear for both sticky registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= 8'd0;
        end else begin
            r_flags <= (w_edge_clr ? 8'd0 : r_flags) | w_new_edges;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 32'd0;
        end else if (w_timer_wr) begin
            r_count <= WriteData;
        end else if (r_count != 32'd0) begin
            r_count <= r_count - 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expired <= 1'b0;
        end else begin
            r_expired <= (r_expired & ~w_status_clr) | w_expire_set;
        end
    end

    // NOTE: ReadData gets a default before the case so no latch is inferred for unlisted offsets.
    always_comb begin
        ReadData = 32'd0;
        if (w_hit) begin
            case (w_off)
                OFF_PORT_OUT: ReadData = r_port_out;
                OFF_PORT_IN:  ReadData = {24'd0, r_sync2};
                OFF_EDGE:     ReadData = {24'd0, r_flags};
                OFF_TIMER:    ReadData = r_count;
                OFF_STATUS:   ReadData = {31'd0, r_expired};
                default:      ReadData = 32'd0;
            endcase
        end
    end

    assign Hit      = w_hit;
    assign PortOut  = r_port_out;
    assign TimerIRQ = r_expired;

endmodule
